// File: rtl/pic_int_pkg.sv
// Shared constants and types for the Timer0 interrupt controller.
package pic_int_pkg;

    localparam int unsigned INTCON_W = 8;

    localparam int unsigned GIE_B    = 7;
    localparam int unsigned PEIE_B   = 6;
    localparam int unsigned TMR0IE_B = 5;
    localparam int unsigned INTE_B   = 4;
    localparam int unsigned IOCIE_B  = 3;
    localparam int unsigned TMR0IF_B = 2;
    localparam int unsigned INTF_B   = 1;
    localparam int unsigned IOCIF_B  = 0;

    localparam logic [6:0]  INTCON_ADDR = 7'h0B;
    localparam int unsigned PC_W_DEF    = 15;
    localparam logic [14:0] VECTOR_DEF  = 15'h0004;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ISR  = 2'd2
    } state_t;

endpackage

// File: rtl/edge_det.sv
// Optional synchronizer followed by a selectable rising/falling edge detector.
// Edges are suppressed until the history register holds a post-reset sample.
module edge_det #(
    parameter int unsigned SYNC_STAGES = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    input  logic edge_sel,
    output logic edge_c
);

    localparam int unsigned VLD_W = SYNC_STAGES + 1;

    logic             s;
    logic             hist_q;
    logic [VLD_W-1:0] vld_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= d;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // vld_q marks when hist_q holds a real sample, so a level present at reset release is not an edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q <= 1'b0;
            vld_q  <= '0;
        end else begin
            hist_q   <= s;
            vld_q[0] <= 1'b1;
            for (int i = 1; i < int'(VLD_W); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign edge_c = vld_q[VLD_W-1] & (edge_sel ? (s & ~hist_q) : (~s & hist_q));

endmodule

// File: rtl/int_ctrl.sv
// INTCON owner and interrupt request/acknowledge FSM downstream of Timer0.
// Optional external INT pin support is enabled by defining INT_PIN_EN.
module int_ctrl
    import pic_int_pkg::*;
#(
    parameter int unsigned     PC_W   = PC_W_DEF,
    parameter logic [PC_W-1:0] VECTOR = PC_W'(VECTOR_DEF)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tmr_flag,
    input  logic                intcon_we,
    input  logic [INTCON_W-1:0] intcon_wdata,
    output logic [INTCON_W-1:0] intcon_rdata,
    output logic                irq_req,
    input  logic                irq_ack,
    output logic [PC_W-1:0]     vector_pc,
`ifdef INT_PIN_EN
    input  logic                int_pin,
    input  logic                int_edge,
`endif
    input  logic                retfie
);

    state_t state_q, state_d;
    logic   gie_q, gie_d;
    logic   peie_q, peie_d;
    logic   tmr0ie_q, tmr0ie_d;
    logic   iocie_q, iocie_d;
    logic   tmr0if_q, tmr0if_d;
    logic   irq_req_d;
    logic   pending_c;
    logic   tmr_rise_c;
    logic   inte_r, intf_r;

    edge_det #(.SYNC_STAGES(0)) u_tmr_edge (
        .clock    (clock),
        .reset    (reset),
        .d        (tmr_flag),
        .edge_sel (1'b1),
        .edge_c   (tmr_rise_c)
    );

`ifdef INT_PIN_EN
    logic inte_q, inte_d;
    logic intf_q, intf_d;
    logic int_edge_c;

    edge_det #(.SYNC_STAGES(2)) u_int_edge (
        .clock    (clock),
        .reset    (reset),
        .d        (int_pin),
        .edge_sel (int_edge),
        .edge_c   (int_edge_c)
    );

    assign inte_r = inte_q;
    assign intf_r = intf_q;
`else
    logic unused_wdata;
    assign unused_wdata = intcon_wdata[INTE_B] ^ intcon_wdata[INTF_B];
    assign inte_r = 1'b0;
    assign intf_r = 1'b0;
`endif

    logic unused_iocif;
    assign unused_iocif = intcon_wdata[IOCIF_B];

    assign pending_c = gie_q & ((tmr0ie_q & tmr0if_q) | (inte_r & intf_r));

    // State and INTCON registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gie_q     <= 1'b0;
            peie_q    <= 1'b0;
            tmr0ie_q  <= 1'b0;
            iocie_q   <= 1'b0;
            tmr0if_q  <= 1'b0;
            irq_req   <= 1'b0;
            vector_pc <= VECTOR;
`ifdef INT_PIN_EN
            inte_q    <= 1'b0;
            intf_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gie_q     <= gie_d;
            peie_q    <= peie_d;
            tmr0ie_q  <= tmr0ie_d;
            iocie_q   <= iocie_d;
            tmr0if_q  <= tmr0if_d;
            irq_req   <= irq_req_d;
            vector_pc <= VECTOR;
`ifdef INT_PIN_EN
            inte_q    <= inte_d;
            intf_q    <= intf_d;
`endif
        end
    end

    // Software write, then hardware flag sets, then FSM control of GIE (highest priority last)
    always_comb begin
        state_d  = state_q;
        gie_d    = gie_q;
        peie_d   = peie_q;
        tmr0ie_d = tmr0ie_q;
        iocie_d  = iocie_q;
        tmr0if_d = tmr0if_q;
`ifdef INT_PIN_EN
        inte_d   = inte_q;
        intf_d   = intf_q;
`endif

        if (intcon_we) begin
            gie_d    = intcon_wdata[GIE_B];
            peie_d   = intcon_wdata[PEIE_B];
            tmr0ie_d = intcon_wdata[TMR0IE_B];
            iocie_d  = intcon_wdata[IOCIE_B];
            tmr0if_d = intcon_wdata[TMR0IF_B];
`ifdef INT_PIN_EN
            inte_d   = intcon_wdata[INTE_B];
            intf_d   = intcon_wdata[INTF_B];
`endif
        end

        if (tmr_rise_c) begin
            tmr0if_d = 1'b1;
        end
`ifdef INT_PIN_EN
        if (int_edge_c) begin
            intf_d = 1'b1;
        end
`endif

        case (state_q)
            IDLE: begin
                if (retfie) begin
                    gie_d = 1'b1;
                end
                if (pending_c) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (retfie) begin
                    gie_d = 1'b1;
                end
                if (irq_ack) begin
                    gie_d   = 1'b0;
                    state_d = ISR;
                end else if (!pending_c) begin
                    state_d = IDLE;
                end
            end
            ISR: begin
                if (retfie) begin
                    gie_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        irq_req_d = (state_d == REQ);
    end

    assign intcon_rdata = {gie_q, peie_q, tmr0ie_q, inte_r, iocie_q, tmr0if_q, intf_r, 1'b0};

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; define INT_PIN_EN to also cover the INT pin path.
module tb_int_ctrl;

    logic        clock;
    logic        reset;
    logic        tmr_flag;
    logic        intcon_we;
    logic [7:0]  intcon_wdata;
    logic [7:0]  intcon_rdata;
    logic        irq_req;
    logic        irq_ack;
    logic [14:0] vector_pc;
    logic        retfie;
`ifdef INT_PIN_EN
    logic        int_pin;
    logic        int_edge;
`endif

    int checks;
    int failures;

    int_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .tmr_flag     (tmr_flag),
        .intcon_we    (intcon_we),
        .intcon_wdata (intcon_wdata),
        .intcon_rdata (intcon_rdata),
        .irq_req      (irq_req),
        .irq_ack      (irq_ack),
        .vector_pc    (vector_pc),
`ifdef INT_PIN_EN
        .int_pin      (int_pin),
        .int_edge     (int_edge),
`endif
        .retfie       (retfie)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples both sit 1 time unit after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_intcon(input logic [7:0] v);
        intcon_we    = 1'b1;
        intcon_wdata = v;
        tick();
        intcon_we    = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        tmr_flag     = 1'b0;
        intcon_we    = 1'b0;
        intcon_wdata = 8'h00;
        irq_ack      = 1'b0;
        retfie       = 1'b0;
`ifdef INT_PIN_EN
        int_pin      = 1'b1;
        int_edge     = 1'b0;
`endif
        #12;
        check("reset_intcon", 32'(intcon_rdata), 32'h00);
        check("reset_irq", 32'(irq_req), 32'h0);
        check("reset_vector", 32'(vector_pc), 32'h0004);

        tick();
        reset = 1'b1;
        repeat (4) tick();

        // Basic Timer0 request path
        write_intcon(8'hA0);
        check("wr_A0", 32'(intcon_rdata), 32'hA0);
        tmr_flag = 1'b1;
        tick();
        check("tmr0if_1clk", 32'(intcon_rdata), 32'hA4);
        check("no_req_1clk", 32'(irq_req), 32'h0);
        tick();
        check("req_2clk", 32'(irq_req), 32'h1);
        check("vector", 32'(vector_pc), 32'h0004);

        // Acknowledge clears GIE, RETFIE restores it
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_drops_req", 32'(irq_req), 32'h0);
        check("ack_intcon", 32'(intcon_rdata), 32'h24);
        retfie = 1'b1;
        tick();
        retfie = 1'b0;
        check("retfie_intcon", 32'(intcon_rdata), 32'hA4);
        check("retfie_idle", 32'(irq_req), 32'h0);
        tick();
        check("req_again", 32'(irq_req), 32'h1);

        // Stuck-high tmr_flag must not re-set TMR0IF
        write_intcon(8'hA0);
        check("clr_if", 32'(intcon_rdata), 32'hA0);
        tick();
        check("req_dropped", 32'(irq_req), 32'h0);
        for (int i = 0; i < 20; i++) begin
            check("stuck_if", 32'(intcon_rdata[2]), 32'h0);
            check("stuck_req", 32'(irq_req), 32'h0);
            tick();
        end
        tmr_flag = 1'b0;
        tick();
        tmr_flag = 1'b1;
        tick();
        check("re_rise_if", 32'(intcon_rdata), 32'hA4);
        tick();
        check("re_rise_req", 32'(irq_req), 32'h1);

        // Hardware set beats a same-cycle software clear
        write_intcon(8'h00);
        tick();
        check("idle_after_clr", 32'(irq_req), 32'h0);
        tmr_flag = 1'b0;
        tick();
        tmr_flag = 1'b1;
        write_intcon(8'h20);
        check("collision", 32'(intcon_rdata), 32'h24);
        check("collision_noreq", 32'(irq_req), 32'h0);
        tick();
        check("collision_noreq2", 32'(irq_req), 32'h0);

        // Withdrawing GIE before the ack cancels the request
        write_intcon(8'hA4);
        check("gie_on", 32'(irq_req), 32'h0);
        tick();
        check("gie_on_req", 32'(irq_req), 32'h1);
        write_intcon(8'h24);
        tick();
        check("withdraw_req", 32'(irq_req), 32'h0);
        check("withdraw_intcon", 32'(intcon_rdata), 32'h24);

        // Ack clear of GIE wins over a same-cycle GIE write; ISR ignores GIE writes
        write_intcon(8'hA4);
        tick();
        check("req_for_isr", 32'(irq_req), 32'h1);
        irq_ack      = 1'b1;
        intcon_we    = 1'b1;
        intcon_wdata = 8'hA4;
        tick();
        irq_ack      = 1'b0;
        intcon_we    = 1'b0;
        check("ack_beats_write", 32'(intcon_rdata), 32'h24);
        check("isr_noreq", 32'(irq_req), 32'h0);
        write_intcon(8'hA4);
        check("isr_gie_write", 32'(intcon_rdata), 32'hA4);
        tick();
        tick();
        check("isr_still_noreq", 32'(irq_req), 32'h0);

        // Asynchronous reset mid-ISR with tmr_flag held high
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_intcon", 32'(intcon_rdata), 32'h00);
        check("async_rst_irq", 32'(irq_req), 32'h0);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check("no_redetect", 32'(intcon_rdata), 32'h00);

        // RETFIE outside ISR sets GIE; ack outside REQ is ignored
        write_intcon(8'h20);
        retfie = 1'b1;
        tick();
        retfie = 1'b0;
        check("retfie_idle_gie", 32'(intcon_rdata), 32'hA0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_idle_ignored", 32'(intcon_rdata), 32'hA0);
        check("ack_idle_noreq", 32'(irq_req), 32'h0);

        // IOCIF and (without the pin option) INTE/INTF are not writable
        write_intcon(8'h5B);
`ifdef INT_PIN_EN
        check("stored_bits", 32'(intcon_rdata), 32'h5A);
`else
        check("stored_bits", 32'(intcon_rdata), 32'h48);
`endif
        write_intcon(8'h00);

`ifdef INT_PIN_EN
        // Falling-edge INT pin: INTF after 3 clocks, request after 4
        write_intcon(8'h90);
        int_edge = 1'b0;
        int_pin  = 1'b0;
        tick();
        check("intf_1clk", 32'(intcon_rdata), 32'h90);
        tick();
        check("intf_2clk", 32'(intcon_rdata), 32'h90);
        tick();
        check("intf_3clk", 32'(intcon_rdata), 32'h92);
        check("int_noreq_3clk", 32'(irq_req), 32'h0);
        tick();
        check("int_req_4clk", 32'(irq_req), 32'h1);
        write_intcon(8'h10);
        tick();
        int_pin = 1'b1;
        repeat (5) tick();
        check("int_wrong_edge", 32'(intcon_rdata), 32'h10);
        check("int_wrong_edge_req", 32'(irq_req), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller directly downstream of Timer0. It consumes the Timer0 overflow flag (TMRFLAG) and owns the INTCON register.
- Sets TMR0IF, gates it with TMR0IE and GIE, and runs the request/acknowledge handshake with the core fetch stage.
- Supplies the interrupt vector to the core. Restores GIE on RETFIE.

Parameters:
- PC_W, 15, program counter width.
- VECTOR, 15'h0004, interrupt vector address driven on vector_pc.

Ports:
- clock  input  1  system clock (Fosc domain, same clock as Timer0).
- reset  input  1  asynchronous, active-low reset.
- tmr_flag  input  1  Timer0 TMRFLAG; level, may stay high indefinitely.
- intcon_we  input  1  core write strobe for INTCON (SFR 0x0B).
- intcon_wdata  input  8  write data.
- intcon_rdata  output  8  current INTCON value.
- irq_req  output  1  interrupt request to core.
- irq_ack  input  1  core accepted the request (PC pushed, vector loaded).
- vector_pc  output  PC_W  equals VECTOR; meaningful while irq_req=1.
- retfie  input  1  single-cycle pulse when the core executes RETFIE.
- int_pin, int_edge  input  1 each  present only with INT_PIN_EN; int_edge is OPTION_REG[6].

Behaviour:
- Reset (reset=0, async): INTCON=8'h00, state=IDLE, irq_req=0, edge history=0, vector_pc=VECTOR.
- INTCON bits: 7 GIE, 6 PEIE, 5 TMR0IE, 4 INTE, 3 IOCIE, 2 TMR0IF, 1 INTF, 0 IOCIF.
  - PEIE and IOCIE are stored only.
  - IOCIF reads 0 and writes are ignored.
- Timer0 edge detect: tmr_q <= tmr_flag every clock. A rise (tmr_flag & ~tmr_q) sets TMR0IF at the same edge.
  - A stuck-high tmr_flag does not re-set TMR0IF after software clears it. A new 0->1 transition is required.
- Flag write collision: a hardware set wins over a software 0 to the same flag in the same cycle. All other bits take the written value.
- FSM, fully registered; irq_req = (state==REQ). pending = GIE & ((TMR0IE&TMR0IF) | (INTE&INTF)).
  - IDLE: pending -> REQ.
  - REQ: irq_ack -> GIE cleared, go to ISR. Else if pending drops (software cleared GIE, IE or IF) -> IDLE, irq_req drops in the same cycle the state changes.
  - ISR: no new request regardless of pending or GIE writes. retfie -> GIE set to 1, go to IDLE.
- Latency: tmr_flag rises before edge k -> TMR0IF=1 after edge k -> irq_req=1 after edge k+1.
- Clearing order at ack: on irq_ack, clearing GIE wins over a simultaneous software write to GIE.
- retfie in IDLE or REQ: sets GIE, state unchanged.
- irq_ack outside REQ: ignored.
- Flags are never cleared by hardware. The ISR must clear TMR0IF/INTF by writing INTCON.
- Reset mid-ISR: returns to IDLE with GIE=0. Any pending tmr_flag level is not re-detected until it transitions.

Optional Feature:
- INT_PIN_EN.
  - Defined: int_pin and int_edge ports exist. int_pin passes through a 2-FF synchronizer plus edge detector; rising edge if int_edge=1, falling if 0. The detected edge sets INTF with the same collision rule. INTE and INTF are writable. Pin-edge-to-INTF latency is 3 clocks.
  - Undefined: both ports are absent, INTE/INTF read 0, writes to them are ignored, and INTF is excluded from pending.

Decomposition:
- Package pic_int_pkg holds:
  - INTCON bit-index constants (GIE_B=7 … IOCIF_B=0).
  - The state enum {IDLE, REQ, ISR}.
  - INTCON_ADDR=7'h0B and the default VECTOR.
- One sub-module, edge_det:
  - Parameters SYNC_STAGES (0 or 2) and an edge-select input.
  - Instantiated for tmr_flag (SYNC_STAGES=0) and for int_pin (SYNC_STAGES=2) under INT_PIN_EN.

Test Plan:
- Reset release, write INTCON=8'hA0 (GIE, TMR0IE), pulse tmr_flag 0->1 -> TMR0IF=1 after 1 clock; irq_req=1 after 2 clocks; vector_pc=15'h0004.
- In REQ, assert irq_ack -> irq_req=0 next clock; intcon_rdata=8'h24. Pulse retfie -> intcon_rdata=8'hA4, state IDLE, irq_req reasserts next clock (flag still set).
- Hold tmr_flag=1, write INTCON=8'hA0 to clear TMR0IF -> TMR0IF stays 0 and irq_req stays 0 for 20 clocks. Drop and re-raise tmr_flag -> TMR0IF=1.
- Same cycle: tmr_flag rise and write INTCON=8'h20 -> intcon_rdata=8'h24 (hardware set wins); no irq_req because GIE=0.
- irq_req=1, then write INTCON=8'h24 (GIE=0) before ack -> irq_req=0 next clock, state IDLE. Assert reset low asynchronously mid-ISR -> intcon_rdata=0 and irq_req=0 immediately.
- INT_PIN_EN: INTCON=8'h90, int_edge=0, drive int_pin 1->0 -> INTF=1 after 3 clocks; irq_req after 4. The opposite edge sets nothing.
